chain_dp_max: RTL and testbench

//  Chaining-DP reduction stage fed directly by computeScorepp. Per anchor i it consumes a stream
//  of candidate beats (score(j,i), f[j], j) and produces f[i] = max(w_i, max_j(f[j]+score)) plus

---
 rtl/chain_pkg.sv | 18 +
 rtl/chain_sat_add.sv | 22 ++
 rtl/chain_dp_max.sv | 143 ++++++++++++++
 tb/tb_chain_dp_max.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chain_pkg.sv
// Shared types and constants for the chaining-DP max reduction stage.
package chain_pkg;

  localparam int unsigned ScoreW = 32;
  localparam int unsigned IdxW   = 16;

  typedef logic signed [ScoreW-1:0] score_t;
  typedef logic [IdxW-1:0]          idx_t;

  localparam idx_t NoPred = '1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StOut  = 2'd2
  } state_e;

endpackage

// File: rtl/chain_sat_add.sv
// Combinational signed adder that clamps the result to the signed W-bit range.
module chain_sat_add #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  logic [W:0] wide;

  always_comb begin
    wide = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    // Top two bits disagree only on overflow; the top bit gives the true sign.
    if (wide[W] != wide[W-1]) begin
      sum_o = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sum_o = wide[W-1:0];
    end
  end

endmodule

// File: rtl/chain_dp_max.sv
// Per-anchor max reduction: f[i] = max(w_i, max_j(f[j] + score)) with best predecessor index.
// Optional early drain after MAX_SKIP non-improving candidates: define CHAIN_MAX_SKIP_EN.
module chain_dp_max
  import chain_pkg::*;
#(
  parameter int unsigned SCORE_W  = ScoreW,
  parameter int unsigned IDX_W    = IdxW,
  parameter int unsigned MAX_SKIP = 25
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_first,
  input  logic               in_last,
  input  logic [SCORE_W-1:0] in_w,
  input  logic               in_sc_vld,
  input  logic [SCORE_W-1:0] in_score,
  input  logic [SCORE_W-1:0] in_f_pred,
  input  logic [IDX_W-1:0]   in_pred_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SCORE_W-1:0] f_out,
  output logic [IDX_W-1:0]   p_out,
  output logic               proto_err
);

  localparam logic [IDX_W-1:0] NoPredIdx = '1;

  state_e state_q, state_d;
  logic signed [SCORE_W-1:0] best_f_q, best_f_d, f_out_q;
  logic signed [SCORE_W-1:0] base_f, sum, new_f;
  logic [IDX_W-1:0]          best_p_q, best_p_d, p_out_q, base_p, new_p;
  logic                      err_q, err_d;
  logic                      accept, in_anchor, load_out, eval_en, improve, drain;
  logic [SCORE_W-1:0]        sum_raw;

  assign in_ready  = (state_q != StOut) || out_ready;
  assign accept    = in_valid && in_ready;
  // A beat belongs to a live anchor if it opens one or continues the current one.
  assign in_anchor = in_first || (state_q == StAcc);

  chain_sat_add #(
    .W (SCORE_W)
  ) u_sat_add (
    .a_i   (in_f_pred),
    .b_i   (in_score),
    .sum_o (sum_raw)
  );

  assign sum     = sum_raw;
  assign base_f  = in_first ? in_w : best_f_q;
  assign base_p  = in_first ? NoPredIdx : best_p_q;
  assign eval_en = in_sc_vld && !drain;
  assign improve = eval_en && (sum > base_f);
  assign new_f   = improve ? sum : base_f;
  assign new_p   = improve ? in_pred_idx : base_p;

`ifdef CHAIN_MAX_SKIP_EN
  localparam int unsigned SkipW = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);

  logic [SkipW-1:0] skip_q, skip_d, skip_base;

  assign skip_base = in_first ? '0 : skip_q;
  assign drain     = (32'(skip_base) >= MAX_SKIP);

  always_comb begin
    skip_d = skip_q;
    if (accept && in_anchor) begin
      if (eval_en) begin
        skip_d = improve ? '0 : skip_base + SkipW'(1);
      end else begin
        skip_d = skip_base;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skip_q <= '0;
    end else begin
      skip_q <= skip_d;
    end
  end
`else
  assign drain = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    best_f_d = best_f_q;
    best_p_d = best_p_q;
    load_out = 1'b0;
    if (accept) begin
      if (in_anchor) begin
        best_f_d = new_f;
        best_p_d = new_p;
        if (in_first && (state_q == StAcc)) begin
          err_d = 1'b1;
        end
        if (in_last) begin
          state_d  = StOut;
          load_out = 1'b1;
        end else begin
          state_d = StAcc;
        end
      end else begin
        // Stray non-first beat outside an anchor; also completes any pending output handshake.
        err_d   = 1'b1;
        state_d = StIdle;
      end
    end else if ((state_q == StOut) && out_ready) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      err_q    <= 1'b0;
      best_f_q <= '0;
      best_p_q <= NoPredIdx;
      f_out_q  <= '0;
      p_out_q  <= NoPredIdx;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      best_f_q <= best_f_d;
      best_p_q <= best_p_d;
      if (load_out) begin
        f_out_q <= new_f;
        p_out_q <= new_p;
      end
    end
  end

  assign out_valid = (state_q == StOut);
  assign f_out     = f_out_q;
  assign p_out     = p_out_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_chain_dp_max.sv
// Directed self-checking bench for chain_dp_max (MAX_SKIP = 2).
module tb_chain_dp_max;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_first, in_last, in_sc_vld;
  logic [31:0] in_w, in_score, in_f_pred;
  logic [15:0] in_pred_idx;
  logic        out_valid, out_ready, proto_err;
  logic [31:0] f_out;
  logic [15:0] p_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  chain_dp_max #(
    .SCORE_W  (32),
    .IDX_W    (16),
    .MAX_SKIP (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_first    (in_first),
    .in_last     (in_last),
    .in_w        (in_w),
    .in_sc_vld   (in_sc_vld),
    .in_score    (in_score),
    .in_f_pred   (in_f_pred),
    .in_pred_idx (in_pred_idx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .f_out       (f_out),
    .p_out       (p_out),
    .proto_err   (proto_err)
  );

  // Drives one beat, waits (bounded) for in_ready, and returns #1 after the accepting edge.
  task automatic send_beat(input logic first, input logic last, input logic [31:0] w,
                           input logic vld, input logic [31:0] sc, input logic [31:0] fp,
                           input logic [15:0] j);
    int n = 0;
    in_valid = 1'b1; in_first = first; in_last = last; in_w = w;
    in_sc_vld = vld; in_score = sc; in_f_pred = fp; in_pred_idx = j;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL beat_ready_timeout: in_ready=%b required 1", in_ready);
      n_fail++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_sc_vld = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid: got %b required 0", out_valid); n_fail++;
    end
    n_checks++;
    if (f_out !== 32'd0) begin
      $display("FAIL reset_f_out: got %h required 0", f_out); n_fail++;
    end
    n_checks++;
    if (p_out !== 16'hFFFF) begin
      $display("FAIL reset_p_out: got %h required ffff", p_out); n_fail++;
    end
    n_checks++;
    if (proto_err !== 1'b0) begin
      $display("FAIL reset_proto_err: got %b required 0", proto_err); n_fail++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b required 1", in_ready); n_fail++;
    end
  endtask

  task automatic test_single();
    send_beat(1'b1, 1'b1, 32'd15, 1'b0, 32'd0, 32'd0, 16'd0);
    n_checks++;
    if (out_valid !== 1'b1) begin
      $display("FAIL single_valid: got %b required 1", out_valid); n_fail++;
    end
    n_checks++;
    if (f_out !== 32'd15) begin
      $display("FAIL single_f: got %0d required 15", $signed(f_out)); n_fail++;
    end
    n_checks++;
    if (p_out !== 16'hFFFF) begin
      $display("FAIL single_p: got %h required ffff", p_out); n_fail++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL single_consumed: out_valid=%b required 0", out_valid); n_fail++;
    end
  endtask

  task automatic test_three_beats();
    send_beat(1'b1, 1'b0, 32'd15, 1'b1, 32'd10, 32'd40, 16'd7);
    n_checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL three_mid_valid: got %b required 0", out_valid); n_fail++;
    end
    send_beat(1'b0, 1'b0, 32'd0, 1'b1, -32'sd5, 32'd50, 16'd5);
    send_beat(1'b0, 1'b1, 32'd0, 1'b1, 32'd0, 32'd45, 16'd3);
    n_checks++;
    if (out_valid !== 1'b1) begin
      $display("FAIL three_valid: got %b required 1", out_valid); n_fail++;
    end
    n_checks++;
    if (f_out !== 32'd50) begin
      $display("FAIL three_f: got %0d required 50", $signed(f_out)); n_fail++;
    end
    n_checks++;
    if (p_out !== 16'd7) begin
      $display("FAIL three_p: got %0d required 7", p_out); n_fail++;
    end
  endtask

  task automatic test_saturation();
    send_beat(1'b1, 1'b1, 32'd0, 1'b1, 32'd100, 32'h7FFF_FFF0, 16'd9);
    n_checks++;
    if (f_out !== 32'h7FFF_FFFF) begin
      $display("FAIL sat_pos_f: got %h required 7fffffff", f_out); n_fail++;
    end
    n_checks++;
    if (p_out !== 16'd9) begin
      $display("FAIL sat_pos_p: got %0d required 9", p_out); n_fail++;
    end
    // Negative clamp lands exactly on w_i, so the strict compare keeps NO_PRED.
    send_beat(1'b1, 1'b1, 32'h8000_0000, 1'b1, -32'sd100, 32'h8000_0010, 16'd4);
    n_checks++;
    if (f_out !== 32'h8000_0000) begin
      $display("FAIL sat_neg_f: got %h required 80000000", f_out); n_fail++;
    end
    n_checks++;
    if (p_out !== 16'hFFFF) begin
      $display("FAIL sat_neg_p: got %h required ffff", p_out); n_fail++;
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_beat(1'b1, 1'b1, 32'd7, 1'b0, 32'd0, 32'd0, 16'd0);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (out_valid !== 1'b1 || f_out !== 32'd7) begin
        $display("FAIL bp_hold[%0d]: valid=%b f=%0d required 1/7", c, out_valid, f_out);
        n_fail++;
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
        $display("FAIL bp_in_ready[%0d]: got %b required 0", c, in_ready); n_fail++;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send_beat(1'b1, 1'b0, 32'd1, 1'b1, 32'd3, 32'd2, 16'd11);
    n_checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL bp_release: out_valid=%b required 0", out_valid); n_fail++;
    end
    send_beat(1'b0, 1'b1, 32'd0, 1'b1, -32'sd1, 32'd10, 16'd12);
    n_checks++;
    if (out_valid !== 1'b1 || f_out !== 32'd9 || p_out !== 16'd12) begin
      $display("FAIL bp_next: valid=%b f=%0d p=%0d required 1/9/12", out_valid, f_out, p_out);
      n_fail++;
    end
  endtask

  task automatic test_protocol();
    send_beat(1'b1, 1'b0, 32'd5, 1'b1, 32'd0, 32'd100, 16'd1);
    send_beat(1'b1, 1'b0, 32'd20, 1'b0, 32'd0, 32'd0, 16'd0);
    n_checks++;
    if (proto_err !== 1'b1) begin
      $display("FAIL proto_restart_err: got %b required 1", proto_err); n_fail++;
    end
    send_beat(1'b0, 1'b1, 32'd0, 1'b1, 32'd0, 32'd30, 16'd2);
    n_checks++;
    if (out_valid !== 1'b1 || f_out !== 32'd30 || p_out !== 16'd2) begin
      $display("FAIL proto_result: valid=%b f=%0d p=%0d required 1/30/2", out_valid, f_out, p_out);
      n_fail++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (proto_err !== 1'b1) begin
      $display("FAIL proto_sticky: got %b required 1", proto_err); n_fail++;
    end
  endtask

  task automatic test_reset_mid_anchor();
    send_beat(1'b1, 1'b0, 32'd3, 1'b1, 32'd1, 32'd8, 16'd6);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || proto_err !== 1'b0) begin
      $display("FAIL rst_mid: valid=%b err=%b required 0/0", out_valid, proto_err); n_fail++;
    end
    n_checks++;
    if (f_out !== 32'd0 || p_out !== 16'hFFFF) begin
      $display("FAIL rst_mid_out: f=%h p=%h required 0/ffff", f_out, p_out); n_fail++;
    end
    @(negedge clk); reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL rst_no_spurious: out_valid=%b required 0", out_valid); n_fail++;
    end
    // Stray non-first beat while idle: dropped and flagged.
    send_beat(1'b0, 1'b1, 32'd0, 1'b1, 32'd5, 32'd5, 16'd1);
    n_checks++;
    if (proto_err !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL idle_stray: err=%b valid=%b required 1/0", proto_err, out_valid); n_fail++;
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_skip();
    logic [31:0] exp_f;
    logic [15:0] exp_p;
`ifdef CHAIN_MAX_SKIP_EN
    exp_f = 32'd10; exp_p = 16'd1;
`else
    exp_f = 32'd20; exp_p = 16'd4;
`endif
    send_beat(1'b1, 1'b0, 32'd0, 1'b1, 32'd0, 32'd10, 16'd1);
    send_beat(1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 32'd5, 16'd2);
    send_beat(1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 32'd3, 16'd3);
    send_beat(1'b0, 1'b1, 32'd0, 1'b1, 32'd0, 32'd20, 16'd4);
    n_checks++;
    if (out_valid !== 1'b1 || f_out !== exp_f) begin
      $display("FAIL skip_f: valid=%b f=%0d required 1/%0d", out_valid, f_out, exp_f); n_fail++;
    end
    n_checks++;
    if (p_out !== exp_p) begin
      $display("FAIL skip_p: got %0d required %0d", p_out, exp_p); n_fail++;
    end
  endtask

  initial begin
    reset = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_sc_vld = 1'b0;
    in_w = '0; in_score = '0; in_f_pred = '0; in_pred_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    test_single();
    test_three_beats();
    test_saturation();
    test_backpressure();
    test_protocol();
    test_reset_mid_anchor();
    test_skip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
